// File: rtl/vga_sprite_timing_gen_if.sv
// rtl/vga_sprite_timing_gen_if.sv - sprite register inputs and composited video outputs of the timing generator
interface vga_sprite_timing_gen_if #(
    parameter int N_SPRITES = 8
);
    logic [23:0]             RGB;
    logic [N_SPRITES-1:0]    SPRITES_FLAGS;
    logic [22*N_SPRITES-1:0] SPRITE_POS;
    logic [24*N_SPRITES-1:0] SPRITE_RGB;

    logic [10:0]             X;
    logic [10:0]             Y;
    logic                    VGA_HS;
    logic                    VGA_VS;
    logic                    VGA_BLANK_N;
    logic [7:0]              VGA_R;
    logic [7:0]              VGA_G;
    logic [7:0]              VGA_B;
    logic [N_SPRITES-1:0]    SPRITES_EN;
    logic                    FRAME_START;

    // The generator drives the video side and samples the game-logic sprite registers.
    modport master (
        input  RGB, SPRITES_FLAGS, SPRITE_POS, SPRITE_RGB,
        output X, Y, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, SPRITES_EN, FRAME_START
    );

    modport slave (
        output RGB, SPRITES_FLAGS, SPRITE_POS, SPRITE_RGB,
        input  X, Y, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, SPRITES_EN, FRAME_START
    );
endinterface

// File: rtl/vga_sprite_timing_gen.sv
// rtl/vga_sprite_timing_gen.sv - parametrised VGA timing generator with prioritised rectangular sprite compositing
module vga_sprite_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int N_SPRITES = 8,
    parameter int SPR_W     = 32,
    parameter int SPR_H     = 32,
    parameter int SYNC_POL  = 0
) (
    input  logic                     VGA_CLK,
    input  logic                     RESET_N,
    vga_sprite_timing_gen_if.master  bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] SPR_W12  = 12'(SPR_W);
    localparam logic [11:0] SPR_H12  = 12'(SPR_H);
    localparam logic        SYNC_ON  = (SYNC_POL != 0);

    logic [10:0] hc;
    logic [10:0] vc;

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    assign bus.X = hc;
    assign bus.Y = vc;

    logic                 pix_active;
    logic                 hs_now;
    logic                 vs_now;
    logic                 fs_now;
    logic [N_SPRITES-1:0] hit_now;
    logic [23:0]          rgb_now;
    logic [11:0]          px;
    logic [11:0]          py;
    logic [11:0]          sx;
    logic [11:0]          sy;

    // Coordinates are widened to 12 bits so that position + size never wraps near the 11-bit limit.
    always_comb begin
        pix_active = (hc < H_ACT) && (vc < V_ACT);
        hs_now     = (hc >= HS_BEG) && (hc < HS_END);
        vs_now     = (vc >= VS_BEG) && (vc < VS_END);
        fs_now     = (hc == 11'd0) && (vc == 11'd0);
        px         = {1'b0, hc};
        py         = {1'b0, vc};
        sx         = '0;
        sy         = '0;
        hit_now    = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            sx = {1'b0, bus.SPRITE_POS[22*i +: 11]};
            sy = {1'b0, bus.SPRITE_POS[22*i+11 +: 11]};
            hit_now[i] = bus.SPRITES_FLAGS[i] && pix_active &&
                         (px >= sx) && (px < sx + SPR_W12) &&
                         (py >= sy) && (py < sy + SPR_H12);
        end
    end

    // Walk from the highest index down so the lowest-index hit is the last writer.
    always_comb begin
        rgb_now = pix_active ? bus.RGB : 24'h000000;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit_now[i]) begin
                rgb_now = bus.SPRITE_RGB[24*i +: 24];
            end
        end
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus.VGA_HS      <= ~SYNC_ON;
            bus.VGA_VS      <= ~SYNC_ON;
            bus.VGA_BLANK_N <= 1'b0;
            bus.VGA_R       <= 8'h00;
            bus.VGA_G       <= 8'h00;
            bus.VGA_B       <= 8'h00;
            bus.SPRITES_EN  <= '0;
            bus.FRAME_START <= 1'b0;
        end else begin
            bus.VGA_HS      <= hs_now ? SYNC_ON : ~SYNC_ON;
            bus.VGA_VS      <= vs_now ? SYNC_ON : ~SYNC_ON;
            bus.VGA_BLANK_N <= pix_active;
            bus.VGA_R       <= rgb_now[23:16];
            bus.VGA_G       <= rgb_now[15:8];
            bus.VGA_B       <= rgb_now[7:0];
            bus.SPRITES_EN  <= hit_now;
            bus.FRAME_START <= fs_now;
        end
    end
endmodule

// File: tb/tb_vga_sprite_timing_gen.sv
// tb/tb_vga_sprite_timing_gen.sv - scoreboard bench for the sprite timing generator on a reduced frame
module tb_vga_sprite_timing_gen;
    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 48;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int NS       = 4;
    localparam int SPR_W    = 8;
    localparam int SPR_H    = 8;
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOT * V_TOT;

    logic VGA_CLK = 1'b0;
    logic RESET_N = 1'b0;

    vga_sprite_timing_gen_if #(.N_SPRITES(NS)) bus ();

    vga_sprite_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .N_SPRITES(NS), .SPR_W(SPR_W), .SPR_H(SPR_H), .SYNC_POL(0)
    ) dut (
        .VGA_CLK(VGA_CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    typedef struct {
        logic          hs;
        logic          vs;
        logic          blank;
        logic [23:0]   rgb;
        logic [NS-1:0] en;
        logic          fs;
        int            h;
        int            v;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     print_cnt = 0;
    bit     mon_on = 0;
    int     mh = 0;
    int     mv = 0;
    longint cyc = 0;
    int     fs_total = 0;
    bit     fs_seen = 0;
    longint fs_cyc_last = 0;
    longint fs_period = 0;
    int     en_cnt[NS];
    int     en_blank_cnt = 0;
    int     watch_cnt = 0;
    logic [23:0] watch_rgb = 24'h000000;
    int     hs_low_cnt = 0;
    int     vs_low_cnt = 0;
    int     blank_hi_cnt = 0;

    int     d_en[NS];
    int     d_enblank, d_watch, d_hs, d_vs, d_blank;

    function automatic exp_t model(int h, int v);
        exp_t e;
        bit   act;
        bit   found;
        int   sx, sy;
        act     = (h < H_ACTIVE) && (v < V_ACTIVE);
        e.hs    = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
        e.vs    = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
        e.blank = act;
        e.fs    = (h == 0) && (v == 0);
        e.en    = '0;
        e.rgb   = act ? bus.RGB : 24'h000000;
        e.h     = h;
        e.v     = v;
        found   = 0;
        for (int i = 0; i < NS; i++) begin
            sx = int'(bus.SPRITE_POS[22*i +: 11]);
            sy = int'(bus.SPRITE_POS[22*i+11 +: 11]);
            if (bus.SPRITES_FLAGS[i] && act && h >= sx && h < sx + SPR_W && v >= sy && v < sy + SPR_H) begin
                e.en[i] = 1'b1;
                if (!found) begin
                    e.rgb = bus.SPRITE_RGB[24*i +: 24];
                    found = 1;
                end
            end
        end
        return e;
    endfunction

    always @(negedge VGA_CLK) begin : monitor
        exp_t e;
        if (mon_on) begin
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.VGA_HS !== e.hs || bus.VGA_VS !== e.vs || bus.VGA_BLANK_N !== e.blank ||
                    {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== e.rgb || bus.SPRITES_EN !== e.en ||
                    bus.FRAME_START !== e.fs) begin
                    errors++;
                    if (print_cnt < 10)
                        $display("FAIL pixel(%0d,%0d) got hs=%b vs=%b blank_n=%b rgb=%h en=%b fs=%b want hs=%b vs=%b blank_n=%b rgb=%h en=%b fs=%b",
                                 e.h, e.v, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N,
                                 {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.SPRITES_EN, bus.FRAME_START,
                                 e.hs, e.vs, e.blank, e.rgb, e.en, e.fs);
                    print_cnt++;
                end
                if (bus.FRAME_START === 1'b1) begin
                    fs_total++;
                    if (fs_seen) fs_period = cyc - fs_cyc_last;
                    fs_cyc_last = cyc;
                    fs_seen = 1;
                end
                for (int i = 0; i < NS; i++)
                    if (bus.SPRITES_EN[i] === 1'b1) en_cnt[i]++;
                if (bus.SPRITES_EN !== '0 && bus.VGA_BLANK_N !== 1'b1) en_blank_cnt++;
                if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} === watch_rgb) watch_cnt++;
                if (bus.VGA_HS === 1'b0) hs_low_cnt++;
                if (bus.VGA_VS === 1'b0) vs_low_cnt++;
                if (bus.VGA_BLANK_N === 1'b1) blank_hi_cnt++;
            end
            checks++;
            if (bus.X !== 11'(mh) || bus.Y !== 11'(mv)) begin
                errors++;
                if (print_cnt < 10)
                    $display("FAIL xy got (%0d,%0d) want (%0d,%0d)", bus.X, bus.Y, mh, mv);
                print_cnt++;
            end
            sb.push_back(model(mh, mv));
            mh++;
            if (mh == H_TOT) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end
        end
    end

    task automatic set_sprite(input int i, input int x, input int y, input logic [23:0] c, input bit f);
        bus.SPRITE_POS[22*i +: 11]    = 11'(x);
        bus.SPRITE_POS[22*i+11 +: 11] = 11'(y);
        bus.SPRITE_RGB[24*i +: 24]    = c;
        bus.SPRITES_FLAGS[i]          = f;
    endtask

    task automatic clear_sprites();
        for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 24'h000000, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge VGA_CLK);
        #1;
        sb.delete();
        mh = 0;
        mv = 0;
        RESET_N = 1'b1;
        mon_on = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.VGA_HS !== 1'b1 || bus.VGA_VS !== 1'b1 || bus.VGA_BLANK_N !== 1'b0) begin
            errors++;
            $display("FAIL %s_sync got hs=%b vs=%b blank_n=%b want 1 1 0", tag, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N);
        end
        checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0 || bus.SPRITES_EN !== '0 || bus.FRAME_START !== 1'b0) begin
            errors++;
            $display("FAIL %s_data got rgb=%h en=%b fs=%b want 0 0 0", tag,
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.SPRITES_EN, bus.FRAME_START);
        end
        checks++;
        if (bus.X !== 11'd0 || bus.Y !== 11'd0) begin
            errors++;
            $display("FAIL %s_xy got (%0d,%0d) want (0,0)", tag, bus.X, bus.Y);
        end
    endtask

    task automatic check_first_pulse(input string tag);
        @(negedge VGA_CLK);
        @(negedge VGA_CLK);
        #1;
        checks++;
        if (bus.FRAME_START !== 1'b1) begin
            errors++;
            $display("FAIL %s_fs_first got %b want 1", tag, bus.FRAME_START);
        end
        @(negedge VGA_CLK);
        #1;
        checks++;
        if (bus.FRAME_START !== 1'b0) begin
            errors++;
            $display("FAIL %s_fs_width got %b want 0", tag, bus.FRAME_START);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int  start;
        bit  ok;
        start = fs_total;
        ok = 0;
        for (int c = 0; c < (n + 1) * FRAME + 16; c++) begin
            @(negedge VGA_CLK);
            #1;
            if (fs_total - start >= n) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout got %0d frame starts want %0d", tag, fs_total - start, n);
        end
    endtask

    task automatic measure_frame(input string tag);
        int s_en[NS];
        int s_bl, s_w, s_hs, s_vs, s_bh;
        wait_frames(1, tag);
        for (int i = 0; i < NS; i++) s_en[i] = en_cnt[i];
        s_bl = en_blank_cnt; s_w = watch_cnt; s_hs = hs_low_cnt; s_vs = vs_low_cnt; s_bh = blank_hi_cnt;
        wait_frames(1, tag);
        for (int i = 0; i < NS; i++) d_en[i] = en_cnt[i] - s_en[i];
        d_enblank = en_blank_cnt - s_bl;
        d_watch   = watch_cnt - s_w;
        d_hs      = hs_low_cnt - s_hs;
        d_vs      = vs_low_cnt - s_vs;
        d_blank   = blank_hi_cnt - s_bh;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        mon_on = 0;
        clear_sprites();
        bus.RGB = 24'h123456;
        repeat (3) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        #1;
        check_reset_outputs("reset_held");
        release_reset();
        check_first_pulse("reset_release");
    endtask

    task automatic test_free_run();
        int first_hs, hs_n, bl_n;
        wait_frames(1, "free_align");
        first_hs = -1; hs_n = 0; bl_n = 0;
        for (int c = 0; c < H_TOT; c++) begin
            if (c > 0) begin
                @(negedge VGA_CLK);
                #1;
            end
            if (bus.VGA_HS === 1'b0) begin
                if (first_hs < 0) first_hs = c;
                hs_n++;
            end
            if (bus.VGA_BLANK_N === 1'b1) bl_n++;
        end
        check_int("hs_start", first_hs, H_ACTIVE + H_FP);
        check_int("hs_width", hs_n, H_SYNC);
        check_int("blank_line", bl_n, H_ACTIVE);
        measure_frame("free_frame");
        check_int("fs_period", int'(fs_period), FRAME);
        check_int("hs_low_frame", d_hs, H_SYNC * V_TOT);
        check_int("vs_low_frame", d_vs, V_SYNC * H_TOT);
        check_int("blank_frame", d_blank, H_ACTIVE * V_ACTIVE);
    endtask

    task automatic test_sprite0();
        @(posedge VGA_CLK);
        #1;
        bus.RGB = 24'h203040;
        clear_sprites();
        set_sprite(0, 10, 12, 24'hAA0011, 1'b1);
        set_sprite(1, 10, 12, 24'h00BB00, 1'b0);
        watch_rgb = 24'hAA0011;
        measure_frame("sprite0");
        check_int("sprite0_hits", d_en[0], SPR_W * SPR_H);
        check_int("sprite0_off1", d_en[1], 0);
        check_int("sprite0_colour", d_watch, SPR_W * SPR_H);
        check_int("sprite0_blank", d_enblank, 0);
    endtask

    task automatic test_clip();
        @(posedge VGA_CLK);
        #1;
        bus.RGB = 24'h0F0F0F;
        clear_sprites();
        set_sprite(2, H_ACTIVE - 4, V_ACTIVE - 4, 24'h5500CC, 1'b1);
        set_sprite(3, H_ACTIVE + 6, 10, 24'h00CC55, 1'b1);
        watch_rgb = 24'h5500CC;
        measure_frame("clip");
        check_int("clip_hits", d_en[2], 16);
        check_int("clip_offscreen", d_en[3], 0);
        check_int("clip_colour", d_watch, 16);
        check_int("clip_blank", d_enblank, 0);
    endtask

    task automatic test_overlap();
        @(posedge VGA_CLK);
        #1;
        bus.RGB = 24'h010203;
        clear_sprites();
        set_sprite(0, 20, 20, 24'hFFFFFF, 1'b0);
        set_sprite(1, 20, 20, 24'h11AA22, 1'b1);
        set_sprite(3, 20, 20, 24'h33CC44, 1'b1);
        watch_rgb = 24'h11AA22;
        measure_frame("overlap");
        check_int("overlap_en1", d_en[1], SPR_W * SPR_H);
        check_int("overlap_en3", d_en[3], SPR_W * SPR_H);
        check_int("overlap_en0_disabled", d_en[0], 0);
        check_int("overlap_colour", d_watch, SPR_W * SPR_H);
    endtask

    task automatic test_mid_reset();
        bit hit;
        @(posedge VGA_CLK);
        #1;
        set_sprite(0, 28, 18, 24'h778899, 1'b1);
        hit = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(posedge VGA_CLK);
            #1;
            if (mh == 30 && mv == 20) begin
                hit = 1;
                break;
            end
        end
        check_int("mid_reset_reach", int'(hit), 1);
        mon_on = 0;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge VGA_CLK);
        release_reset();
        check_first_pulse("mid_release");
        wait_frames(2, "mid_period");
        check_int("mid_fs_period", int'(fs_period), FRAME);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) en_cnt[i] = 0;
        bus.RGB = 24'h0;
        bus.SPRITES_FLAGS = '0;
        bus.SPRITE_POS = '0;
        bus.SPRITE_RGB = '0;
        test_reset();
        test_free_run();
        test_sprite0();
        test_clip();
        test_overlap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
